// File: rtl/fb_fill_writer_pkg.sv
// Shared framebuffer definitions: raster geometry defaults, fill FSM encoding,
// command payload layout and the SRAM pixel word format.
package fb_fill_writer_pkg;

    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned V_ACTIVE_DEF = 600;
    localparam int unsigned ADDR_W_DEF   = 20;

    localparam int unsigned COORD_W = 12;  // command coordinate width
    localparam int unsigned CLIP_W  = 13;  // clip arithmetic width (x+w never overflows)
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_FIN   = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] color;
    } fill_cmd_t;

    // {pad, R, G, B} word as stored in the SRAM
    function automatic logic [DATA_W-1:0] pixel_word(input logic [COLOR_W-1:0] color);
        return {8'h00, color};
    endfunction

endpackage

// File: rtl/fb_addr_step.sv
// Row/column walker for a clipped rectangle.
// Ports: load (latch origin, clip limits, start address), step (advance one
// pixel row-major), addr (registered current pixel address), last_c (current
// pixel is the final one of the rectangle).
module fb_addr_step
    import fb_fill_writer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [CLIP_W-1:0] x0,
    input  logic [CLIP_W-1:0] y0,
    input  logic [CLIP_W-1:0] xe,
    input  logic [CLIP_W-1:0] ye,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    logic [CLIP_W-1:0] col_q, row_q, x0_q, xe_q, ye_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              col_last_c, row_last_c;

    assign col_last_c = (CLIP_W'(col_q + CLIP_W'(1)) == xe_q);
    assign row_last_c = (CLIP_W'(row_q + CLIP_W'(1)) == ye_q);
    assign last_c     = col_last_c && row_last_c;

    // Column increments address by one; row wrap jumps to next row base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            x0_q       <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            row_base_q <= '0;
            addr       <= '0;
        end else if (load) begin
            col_q      <= x0;
            row_q      <= y0;
            x0_q       <= x0;
            xe_q       <= xe;
            ye_q       <= ye;
            row_base_q <= start_addr;
            addr       <= start_addr;
        end else if (step) begin
            if (col_last_c) begin
                col_q      <= x0_q;
                row_q      <= CLIP_W'(row_q + CLIP_W'(1));
                row_base_q <= ADDR_W'(row_base_q + ADDR_W'(H_ACTIVE));
                addr       <= ADDR_W'(row_base_q + ADDR_W'(H_ACTIVE));
            end else begin
                col_q <= CLIP_W'(col_q + CLIP_W'(1));
                addr  <= ADDR_W'(addr + ADDR_W'(1));
            end
        end
    end

endmodule

// File: rtl/fb_fill_writer.sv
// Solid-rectangle fill engine: accepts a clipped fill command and writes one
// 32-bit pixel word per granted SRAM slot, row-major.
// Ports: cmd_* (command handshake and rectangle/colour), wr_grant (SRAM slot
// available), sram_wr_en/addr/data (write request held until granted),
// done (one-cycle completion pulse).
module fb_fill_writer
    import fb_fill_writer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               wr_grant,
    output logic               sram_wr_en,
    output logic [ADDR_W-1:0]  sram_wr_addr,
    output logic [DATA_W-1:0]  sram_wr_data,
    output logic               done
);

    if (64'(H_ACTIVE) * 64'(V_ACTIVE) > (64'd1 << ADDR_W)) begin : g_addr_w_check
        $error("ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
    end

    localparam logic [CLIP_W-1:0] H_LIM = CLIP_W'(H_ACTIVE);
    localparam logic [CLIP_W-1:0] V_LIM = CLIP_W'(V_ACTIVE);

    fill_state_t       state_q, state_d;
    fill_cmd_t         cmd_q;
    logic              accept_c, empty_c, step_c, last_c;
    logic [CLIP_W-1:0] x0_c, y0_c, xs_c, ys_c, xe_c, ye_c;
    logic [ADDR_W-1:0] start_addr_c;
    logic              ready_d, done_d, wr_en_d;

    assign accept_c = cmd_valid && cmd_ready;
    assign step_c   = sram_wr_en && wr_grant;

    // Clip against the active area in 13 bits.
    always_comb begin
        x0_c    = {1'b0, cmd_q.x};
        y0_c    = {1'b0, cmd_q.y};
        xs_c    = CLIP_W'(x0_c + {1'b0, cmd_q.w});
        ys_c    = CLIP_W'(y0_c + {1'b0, cmd_q.h});
        xe_c    = (xs_c > H_LIM) ? H_LIM : xs_c;
        ye_c    = (ys_c > V_LIM) ? V_LIM : ys_c;
        empty_c = (cmd_q.w == '0) || (cmd_q.h == '0) || (x0_c >= H_LIM) || (y0_c >= V_LIM);
    end

    // Start address y*H_ACTIVE + x as a constant shift-add.
    always_comb begin
        start_addr_c = ADDR_W'(cmd_q.x);
        for (int i = 0; i < 32; i++) begin
            if (H_ACTIVE[i]) begin
                start_addr_c = ADDR_W'(start_addr_c + (ADDR_W'(cmd_q.y) << i));
            end
        end
    end

    fb_addr_step #(
        .H_ACTIVE (H_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_addr_step (
        .clk        (clk),
        .rst        (rst),
        .load       (state_q == ST_SETUP),
        .step       (step_c),
        .x0         (x0_c),
        .y0         (y0_c),
        .xe         (xe_c),
        .ye         (ye_c),
        .start_addr (start_addr_c),
        .addr       (sram_wr_addr),
        .last_c     (last_c)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c) state_d = ST_SETUP;
            ST_SETUP: state_d = empty_c ? ST_FIN : ST_FILL;
            ST_FILL:  if (step_c && last_c) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_FIN);
        wr_en_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_ready    <= 1'b1;
            done         <= 1'b0;
            sram_wr_en   <= 1'b0;
            sram_wr_data <= '0;
            cmd_q        <= '0;
        end else begin
            state_q    <= state_d;
            cmd_ready  <= ready_d;
            done       <= done_d;
            sram_wr_en <= wr_en_d;
            if (accept_c) begin
                cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
            end
            if (state_q == ST_SETUP) begin
                sram_wr_data <= pixel_word(cmd_q.color);
            end
        end
    end

endmodule
